// File: rtl/matrix_scan_driver_if.sv
// Frame-load handshake and scan outputs of the 5x7 LED matrix row-scan driver.
// The driver takes the slave view; the frame source / display side takes the master view.
interface matrix_scan_driver_if;
    logic [34:0] frame_in;
    logic        frame_valid;
    logic        frame_ready;
    logic [6:0]  row_en;
    logic [4:0]  col;
    logic [2:0]  row_idx;
    logic        frame_start;

    modport master (
        output frame_in,
        output frame_valid,
        input  frame_ready,
        input  row_en,
        input  col,
        input  row_idx,
        input  frame_start
    );

    modport slave (
        input  frame_in,
        input  frame_valid,
        output frame_ready,
        output row_en,
        output col,
        output row_idx,
        output frame_start
    );
endinterface

// File: rtl/matrix_scan_driver.sv
// Row-scan driver for a 5x7 LED matrix: double-buffered 35-bit frame, one-hot row
// strobes with a blanking gap between rows, registered column data for the driven row.
module matrix_scan_driver #(
    parameter int DWELL = 1000,
    parameter int BLANK = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    matrix_scan_driver_if.slave   bus
);

    localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? (BLANK - 1) : 0);
    localparam logic [2:0]    LAST_ROW   = 3'd6;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [2:0]      r_row_idx;
    logic [2:0]      w_row_nxt;
    logic            w_frame_end;

    logic [34:0]     r_active;
    logic [34:0]     r_shadow;
    logic [34:0]     w_active_nxt;
    logic            r_pending;
    logic            w_pending_nxt;
    logic            w_capture;
    logic            w_swap;

    logic [6:0]      r_row_en;
    logic [6:0]      w_row_en_nxt;
    logic [4:0]      r_col;
    logic [4:0]      w_col_nxt;
    logic            r_frame_start;
    logic            w_frame_start_nxt;

    function automatic logic [6:0] row_onehot(input logic [2:0] idx);
        logic [6:0] oh;
        case (idx)
            3'd0:    oh = 7'b0000001;
            3'd1:    oh = 7'b0000010;
            3'd2:    oh = 7'b0000100;
            3'd3:    oh = 7'b0001000;
            3'd4:    oh = 7'b0010000;
            3'd5:    oh = 7'b0100000;
            3'd6:    oh = 7'b1000000;
            default: oh = 7'b0000000;
        endcase
        return oh;
    endfunction

    // Row r of a frame sits in bits [5r+4:5r], column A in the low bit.
    function automatic logic [4:0] row_slice(input logic [34:0] frame, input logic [2:0] idx);
        logic [4:0] s;
        case (idx)
            3'd0:    s = frame[4:0];
            3'd1:    s = frame[9:5];
            3'd2:    s = frame[14:10];
            3'd3:    s = frame[19:15];
            3'd4:    s = frame[24:20];
            3'd5:    s = frame[29:25];
            3'd6:    s = frame[34:30];
            default: s = 5'b00000;
        endcase
        return s;
    endfunction

    // Scan sequencer: blank gap, then dwell on the row, then advance the row index.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_row_nxt   = r_row_idx;
        w_frame_end = 1'b0;
        case (r_state)
            ST_BLANK: begin
                if ((BLANK == 0) || (r_cnt == BLANK_LAST)) begin
                    w_state_nxt = ST_DRIVE;
                    w_cnt_nxt   = {CW{1'b0}};
                end else begin
                    w_cnt_nxt   = r_cnt + CW'(1);
                end
            end
            ST_DRIVE: begin
                if (r_cnt == DWELL_LAST) begin
                    w_cnt_nxt   = {CW{1'b0}};
                    w_state_nxt = (BLANK == 0) ? ST_DRIVE : ST_BLANK;
                    if (r_row_idx == LAST_ROW) begin
                        w_frame_end = 1'b1;
                        w_row_nxt   = 3'd0;
                    end else begin
                        w_row_nxt   = r_row_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt   = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_BLANK;
                w_cnt_nxt   = {CW{1'b0}};
                w_row_nxt   = 3'd0;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_BLANK;
            r_cnt     <= {CW{1'b0}};
            r_row_idx <= 3'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_row_idx <= w_row_nxt;
        end
    end

    // Capture needs a free shadow and the swap needs a full one, so they never collide.
    always_comb begin
        w_capture     = bus.frame_valid && !r_pending;
        w_swap        = w_frame_end && r_pending;
        w_active_nxt  = w_swap ? r_shadow : r_active;
        if (w_capture) begin
            w_pending_nxt = 1'b1;
        end else if (w_swap) begin
            w_pending_nxt = 1'b0;
        end else begin
            w_pending_nxt = r_pending;
        end
    end

    // Output decode from the next state so strobes and data land together with the state.
    always_comb begin
        w_row_en_nxt      = 7'b0000000;
        w_col_nxt         = 5'b00000;
        w_frame_start_nxt = 1'b0;
        if (w_state_nxt == ST_DRIVE) begin
            w_row_en_nxt      = row_onehot(w_row_nxt);
            w_col_nxt         = row_slice(w_active_nxt, w_row_nxt);
            w_frame_start_nxt = (w_row_nxt == 3'd0) && (w_cnt_nxt == {CW{1'b0}});
        end else begin
            w_row_en_nxt      = 7'b0000000;
            w_col_nxt         = 5'b00000;
            w_frame_start_nxt = 1'b0;
        end
    end

    // Frame buffers and registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active      <= 35'd0;
            r_shadow      <= 35'd0;
            r_pending     <= 1'b0;
            r_row_en      <= 7'b0000000;
            r_col         <= 5'b00000;
            r_frame_start <= 1'b0;
        end else begin
            if (w_capture) begin
                r_shadow <= bus.frame_in;
            end else begin
                r_shadow <= r_shadow;
            end
            r_active      <= w_active_nxt;
            r_pending     <= w_pending_nxt;
            r_row_en      <= w_row_en_nxt;
            r_col         <= w_col_nxt;
            r_frame_start <= w_frame_start_nxt;
        end
    end

    assign bus.frame_ready = !r_pending;
    assign bus.row_en      = r_row_en;
    assign bus.col         = r_col;
    assign bus.row_idx     = r_row_idx;
    assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Bench for matrix_scan_driver: startup table, frame load, double buffering,
// backpressure, async reset mid-scan, and a BLANK=0 instance.
module tb_matrix_scan_driver;

    typedef struct packed {
        logic [6:0] row_en;
        logic [4:0] col;
        logic [2:0] row_idx;
        logic       fs;
        logic       ready;
    } exp_t;

    typedef struct {
        logic        v;
        logic [34:0] d;
        exp_t        e;
    } vec_t;

    logic clk;
    logic rst_n;
    logic rst2_n;

    matrix_scan_driver_if m1();
    matrix_scan_driver_if m2();

    matrix_scan_driver #(.DWELL(4), .BLANK(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m1)
    );

    matrix_scan_driver #(.DWELL(4), .BLANK(0)) dut0 (
        .clk   (clk),
        .rst_n (rst2_n),
        .bus   (m2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          k;
    logic [34:0] m_act;
    logic [34:0] m_shadow;
    logic        m_pend;
    exp_t        sb[$];
    vec_t        tab[8];

    // Expected outputs in the interval after the k-th edge since reset release.
    function automatic exp_t model_exp(input int kk, input int b, input logic [34:0] act,
                                       input logic pend);
        exp_t e;
        int   per;
        int   p;
        int   r;
        int   ph;
        per = 4 + b;
        p   = (b == 0) ? ((kk - 1) % (7 * per)) : (kk % (7 * per));
        r   = p / per;
        ph  = p % per;
        e.row_idx = 3'(r);
        e.ready   = ~pend;
        if (ph >= b) begin
            e.row_en = 7'(1 << r);
            e.col    = act[5*r +: 5];
            e.fs     = (p == b);
        end else begin
            e.row_en = 7'd0;
            e.col    = 5'd0;
            e.fs     = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic cmp_exp(input string nm, input exp_t got, input exp_t want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s k=%0d: got row_en=%b col=%b row_idx=%0d fs=%b ready=%b, want row_en=%b col=%b row_idx=%0d fs=%b ready=%b",
                     nm, k, got.row_en, got.col, got.row_idx, got.fs, got.ready,
                     want.row_en, want.col, want.row_idx, want.fs, want.ready);
        end
    endtask

    // One clock of the BLANK=2 instance: drive, update model at the edge, push, then compare.
    task automatic step(input logic v, input logic [34:0] d, input bit use_tab, input exp_t te);
        exp_t want;
        exp_t got;
        m1.frame_valid = v;
        m1.frame_in    = d;
        @(posedge clk);
        k++;
        if ((k % 42 == 0) && m_pend) begin
            m_act  = m_shadow;
            m_pend = 1'b0;
        end else if (v && !m_pend) begin
            m_shadow = d;
            m_pend   = 1'b1;
        end
        sb.push_back(use_tab ? te : model_exp(k, 2, m_act, m_pend));
        @(negedge clk);
        want = sb.pop_front();
        got  = {m1.row_en, m1.col, m1.row_idx, m1.frame_start, m1.frame_ready};
        cmp_exp(use_tab ? "startup" : "scan", got, want);
    endtask

    task automatic model_reset();
        k        = 0;
        m_act    = 35'd0;
        m_shadow = 35'd0;
        m_pend   = 1'b0;
    endtask

    initial begin
        logic [34:0] fa;
        logic [34:0] fb;
        logic [34:0] fc;
        exp_t        nul;
        exp_t        got2;
        exp_t        want2;

        nul = '0;
        for (int r = 0; r < 7; r++) fa[5*r +: 5] = 5'(r + 1);
        fb = {35{1'b1}};
        fc = 35'h5_A5C3_9E17;

        // {valid, data, {row_en, col, row_idx, fs, ready}} for edges 1..8 after release
        tab[0] = '{1'b0, 35'd0, '{7'b0000000, 5'd0, 3'd0, 1'b0, 1'b1}};
        tab[1] = '{1'b0, 35'd0, '{7'b0000001, 5'd0, 3'd0, 1'b1, 1'b1}};
        tab[2] = '{1'b0, 35'd0, '{7'b0000001, 5'd0, 3'd0, 1'b0, 1'b1}};
        tab[3] = '{1'b0, 35'd0, '{7'b0000001, 5'd0, 3'd0, 1'b0, 1'b1}};
        tab[4] = '{1'b0, 35'd0, '{7'b0000001, 5'd0, 3'd0, 1'b0, 1'b1}};
        tab[5] = '{1'b0, 35'd0, '{7'b0000000, 5'd0, 3'd1, 1'b0, 1'b1}};
        tab[6] = '{1'b0, 35'd0, '{7'b0000000, 5'd0, 3'd1, 1'b0, 1'b1}};
        tab[7] = '{1'b0, 35'd0, '{7'b0000010, 5'd0, 3'd1, 1'b0, 1'b1}};

        rst_n          = 1'b0;
        rst2_n         = 1'b0;
        m1.frame_valid = 1'b0;
        m1.frame_in    = 35'd0;
        m2.frame_valid = 1'b0;
        m2.frame_in    = 35'd0;
        model_reset();

        #3;
        chk("rst_row_en", 32'(m1.row_en), 32'd0);
        chk("rst_col", 32'(m1.col), 32'd0);
        chk("rst_ready", 32'(m1.frame_ready), 32'd1);
        chk("rst_row_idx", 32'(m1.row_idx), 32'd0);
        chk("rst_fs", 32'(m1.frame_start), 32'd0);
        repeat (2) @(negedge clk);
        chk("rst_hold_row_en", 32'(m1.row_en), 32'd0);

        rst_n = 1'b1;
        #1;
        chk("rel_row_en", 32'(m1.row_en), 32'd0);
        chk("rel_ready", 32'(m1.frame_ready), 32'd1);
        #1;

        for (int i = 0; i < 8; i++) step(tab[i].v, tab[i].d, 1'b1, tab[i].e);

        // frame A before the first boundary, B during row 3 of the frame showing A
        step(1'b1, fa, 1'b0, nul);
        while (k < 61) step(1'b0, 35'd0, 1'b0, nul);
        step(1'b1, fb, 1'b0, nul);
        while (k < 69) step(1'b0, 35'd0, 1'b0, nul);
        // C held valid across the swap
        while (k < 85) step(1'b1, fc, 1'b0, nul);
        while (k < 147) step(1'b0, 35'd0, 1'b0, nul);

        // async reset during DRIVE of row 3, between edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_row_en", 32'(m1.row_en), 32'd0);
        chk("async_col", 32'(m1.col), 32'd0);
        chk("async_ready", 32'(m1.frame_ready), 32'd1);
        chk("async_row_idx", 32'(m1.row_idx), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        chk("rerel_row_en", 32'(m1.row_en), 32'd0);
        while (k < 90) step(1'b0, 35'd0, 1'b0, nul);

        // BLANK=0 instance: contiguous one-hot rows, 28-cycle period
        @(negedge clk);
        rst2_n = 1'b1;
        for (int j = 1; j <= 70; j++) begin
            @(posedge clk);
            sb.push_back(model_exp(j, 0, 35'd0, 1'b0));
            @(negedge clk);
            want2 = sb.pop_front();
            got2  = {m2.row_en, m2.col, m2.row_idx, m2.frame_start, m2.frame_ready};
            k     = j;
            cmp_exp("blank0", got2, want2);
            chk("blank0_onehot", 32'($onehot(m2.row_en)), 32'd1);
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matrix_scan_driver.md
Name: matrix_scan_driver

Overview:
Sequential row-scan driver for the 5x7 LED matrix. It accepts a 35-bit frame over a valid/ready handshake and double-buffers it. It generates the one-hot row strobes (l0..l6) and drives the registered column outputs (A..E) for the active row. Blanking gaps between rows suppress ghosting. It is the scanning end of the matrix display path: it produces the row-select sequence and row data that the column-select mux consumes.

Parameters:
DWELL, 1000, clock cycles each row is driven (must be >= 1)
BLANK, 16, clock cycles with all rows off between consecutive rows (0 allowed = no gap)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
frame_in  input  35  new frame; row r occupies bits [5r+4:5r]; bit 5r+0 = column A ... bit 5r+4 = column E
frame_valid  input  1  frame_in valid
frame_ready  output  1  shadow buffer free; frame captured on a clk edge with frame_valid && frame_ready
row_en  output  7  one-hot row strobe; bit r drives row r (l0..l6)
col  output  5  column data for the driven row; col[0] = A ... col[4] = E
row_idx  output  3  index of the current or next row to drive (0..6)
frame_start  output  1  one-cycle pulse in the first DRIVE cycle of row 0

Behaviour:
- Reset is asynchronous and active-low, applied immediately and independent of clk. Reset values:
  - state=BLANK, cycle counter=0, row_idx=0
  - active buffer=0, shadow buffer=0, pending=0
  - row_en=0, col=0, frame_start=0
- frame_ready = !pending (combinational), so it is 1 while in reset and after release.
- Capture: on a clk edge with frame_valid && frame_ready, shadow <= frame_in and pending <= 1. frame_valid with frame_ready=0 is ignored; the sender must hold.
- FSM, two states:
  - BLANK: row_en=0, col=0. The state lasts exactly BLANK cycles, then goes to DRIVE. If BLANK=0, DRIVE follows DRIVE directly with no zero cycle.
  - DRIVE: row_en = one-hot(row_idx), col = active[5*row_idx +: 5]. The state lasts exactly DWELL cycles. On its final cycle, row_idx wraps 6->0 (else +1) and the FSM goes to BLANK.
- row_en and col are registered and change on the same edge. At most one row_en bit is ever high.
- Buffer swap: on the DRIVE->BLANK transition with row_idx==6, if pending=1 then active <= shadow and pending <= 0. frame_ready rises the cycle after the swap.
- Captures and swaps can never coincide, because a capture requires pending=0 and a swap requires pending=1.
- The active buffer changes only at a frame boundary. A displayed frame is never torn.
- frame_start is 1 only in the first DRIVE cycle with row_idx==0.
- Frame period = 7*(DWELL+BLANK) cycles.
- Counter is wide enough for max(DWELL,BLANK)-1. No other arithmetic.
- Reset asserted mid-operation: outputs go to reset values immediately and both buffers are lost. After release, the scan restarts with BLANK, then row 0.

Test Plan:
- Reset/startup (DWELL=4, BLANK=2): while rst_n=0, row_en=0, col=0, frame_ready=1, row_idx=0. After release: 2 cycles row_en=0, then row_en=7'b0000001 for 4 cycles with col=0, and frame_start high in the first of those cycles.
- Frame display: load a frame with row r = r+1 (row0=5'b00001 ... row6=5'b00111) before the first frame boundary. In the next frame, row_en=1<<r shows col=r+1 for 4 cycles each, with exactly 2 zero cycles between rows. frame_start repeats every 42 cycles.
- Double buffering: load frame B (all 5'b11111) during row 3 of frame A. Rows 3..6 still show A, frame_ready=0 from the cycle after capture, and row 0 of the next frame shows 5'b11111. frame_ready returns to 1 after the swap.
- Backpressure: present frame C with frame_valid held high while pending=1. It is not captured, and frame_ready stays 0. C is captured on the first edge after the swap and displayed one frame later.
- Async reset mid-scan: assert rst_n low between clk edges during DRIVE of row 3. row_en=0, col=0 and frame_ready=1 with no clock edge. After release, the display is blank (active=0) and scanning restarts at row 0 after 2 blank cycles.
- BLANK=0 corner: rows are contiguous (row_en never 0 after startup), always one-hot, and the period is 28 cycles.
